aes_word_loader: RTL
====================

AES_WORD_LOADER -- requirements
Module: aes_word_loader

Interface
REQ-001: The module SHALL have no parameters; all widths are fixed.
REQ-002: clk  input  1  clock; all logic SHALL be sampled on its rising edge.
REQ-003: rst  input  1  reset, synchronous, active-high.
REQ-004: key_wr  input  1  key write strobe, accepted per REQ-012.
REQ-005: key_wdata  input  128  AES-128 key, big-endian byte order.
REQ-006: in_valid / in_ready  input / output  1 / 1  handshake for the plaintext word stream.
REQ-007: in_data  input  32  plaintext word; the first word of a block SHALL be bits [127:96].
REQ-008: core_start  output  1  single-cycle start pulse to the AES core.
REQ-009: core_key / core_plaintext  output  128 / 128  key register and assembled block, driven to the core.
REQ-010: core_busy / core_done / core_ciphertext  input  1 / 1 / 128  status and result from the AES core.
REQ-011: out_valid / out_ready / out_data / out_last  output / input / output / output  1 / 1 / 32 / 1  ciphertext word stream; out_last marks the 4th word.

Function
REQ-012: key_wr SHALL load key_wdata into the key register only in state FILL with word count 0; at any other time it SHALL be ignored.
REQ-013: The FSM states SHALL be FILL, START, WAIT and DRAIN; FILL is the reset state.
REQ-014: FILL: in_ready=1; each in_valid&&in_ready beat SHALL store in_data at word index cnt (0..3) and increment cnt.
REQ-015: FILL -> START: in the cycle the 4th word is accepted; cnt SHALL wrap to 0.
REQ-016: START: core_start=1 for exactly one cycle when core_busy=0, then go to WAIT; while core_busy=1, stay in START with core_start=0.
REQ-017: WAIT: on core_done=1, capture core_ciphertext into the output buffer and go to DRAIN; in this state in_ready=0.
REQ-018: DRAIN: out_valid=1; out_data SHALL be output word cnt (word 0 = bits [127:96]); each out_valid&&out_ready beat SHALL advance cnt.
REQ-019: out_last SHALL be 1 only while out_valid=1 and cnt=3; DRAIN -> FILL SHALL occur when that beat is accepted.
REQ-020: out_valid and out_data SHALL remain stable while out_ready=0.
REQ-021: in_ready SHALL be 0 in START, WAIT and DRAIN; in_valid in those states SHALL have no effect.
REQ-022: core_done outside WAIT SHALL be ignored.
REQ-023: core_plaintext SHALL hold the assembled block, unchanged from START until the next FILL beat.
REQ-024: Latency: core_start SHALL assert in the cycle after the 4th input beat, provided core_busy=0.
REQ-025: Latency: out_valid SHALL assert in the cycle after core_done is sampled in WAIT.
REQ-026: Throughput: one block in flight; the next input word SHALL be accepted no earlier than the cycle after the out_last beat.

Reset
REQ-027: While rst=1, the state SHALL be FILL, cnt=0, and the key, block and output-buffer registers SHALL be 0.
REQ-028: While rst=1, in_ready=0, core_start=0, out_valid=0 and out_last=0; out_data, core_key and core_plaintext SHALL read 0.
REQ-029: in_ready=1 SHALL first be seen in the cycle after rst deasserts.
REQ-030: rst asserted in any state, including mid-block and mid-drain, SHALL abort the block; no partial output SHALL be emitted afterwards.

Configuration
REQ-031: Macro AES_LOADER_LE_EN defined: in_data and out_data SHALL be byte-reversed per 32-bit word (in_data[7:0] becomes the most significant byte of the stored word).
REQ-032: Macro AES_LOADER_LE_EN undefined: words SHALL pass unswapped; key_wdata SHALL never be swapped in either build.

Verification
REQ-033: Key 000102030405060708090a0b0c0d0e0f; words 00112233, 44556677, 8899aabb, ccddeeff -> out words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a, out_last on the 4th.
REQ-034: Same vector with out_ready toggled 1/0 every cycle -> identical words, each held stable while stalled, exactly one out_last.
REQ-035: core_busy=1 when the 4th word is accepted -> core_start stays 0 until busy falls, then pulses for exactly one cycle.
REQ-036: rst pulse after 2 input words, then the full vector -> correct ciphertext; the stale words are not used.
REQ-037: key_wr during WAIT with a different key -> the current block result is unchanged and the key register retains the old key.
REQ-038: AES_LOADER_LE_EN build, in_data 33221100 ... -> core_plaintext 00112233...; out words d8e0c469 ...

Source files
------------

// File: rtl/aes_word_loader_if.sv
// aes_word_loader_if: key, plaintext-in, AES-core and ciphertext-out signals of aes_word_loader.
interface aes_word_loader_if;
  logic         key_wr;
  logic [127:0] key_wdata;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         core_start;
  logic [127:0] core_key;
  logic [127:0] core_plaintext;
  logic         core_busy;
  logic         core_done;
  logic [127:0] core_ciphertext;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;
  modport master (
    output key_wr, key_wdata, in_valid, in_data, core_busy, core_done, core_ciphertext, out_ready,
    input  in_ready, core_start, core_key, core_plaintext, out_valid, out_data, out_last
  );
  modport slave (
    input  key_wr, key_wdata, in_valid, in_data, core_busy, core_done, core_ciphertext, out_ready,
    output in_ready, core_start, core_key, core_plaintext, out_valid, out_data, out_last
  );
endinterface

// File: rtl/aes_word_loader.sv
// aes_word_loader: packs 4 x 32-bit words into an AES-128 block, runs the core, streams the result as 4 words.
// Define AES_LOADER_LE_EN to byte-reverse every in_data/out_data word (key is never swapped).
module aes_word_loader (
  input logic clk,
  input logic rst,
  aes_word_loader_if.slave bus
);
  typedef enum logic [1:0] {FILL, START, WAIT, DRAIN} state_t;
  state_t state, nxt;
  logic [1:0] cnt;
  logic [127:0] key, blk, obuf;
  logic in_fire, out_fire;
  function automatic logic [31:0] sw(input logic [31:0] w);
`ifdef AES_LOADER_LE_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction
  // Outputs are gated by rst so they read 0 even before the first reset edge.
  assign bus.in_ready       = !rst && state == FILL;
  assign bus.core_start     = !rst && state == START && !bus.core_busy;
  assign bus.out_valid      = !rst && state == DRAIN;
  assign bus.out_last       = bus.out_valid && cnt == 2'd3;
  assign bus.out_data       = rst ? '0 : sw(obuf[{~cnt, 5'd0} +: 32]);
  assign bus.core_key       = rst ? '0 : key;
  assign bus.core_plaintext = rst ? '0 : blk;
  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;
  always_comb begin
    nxt = state;
    case (state)
      FILL:    nxt = in_fire && cnt == 2'd3 ? START : FILL;
      START:   nxt = bus.core_start ? WAIT : START;
      WAIT:    nxt = bus.core_done ? DRAIN : WAIT;
      DRAIN:   nxt = out_fire && bus.out_last ? FILL : DRAIN;
      default: nxt = FILL;
    endcase
  end
  always_ff @(posedge clk) state <= rst ? FILL : nxt;
  // Word 0 lives in bits [127:96]; {~cnt,5'd0} is (3-cnt)*32.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      key  <= '0;
      blk  <= '0;
      obuf <= '0;
    end else begin
      if (bus.key_wr && state == FILL && cnt == 2'd0) key <= bus.key_wdata;
      if (in_fire) blk[{~cnt, 5'd0} +: 32] <= sw(bus.in_data);
      if (in_fire || out_fire) cnt <= cnt + 2'd1;
      if (state == WAIT && bus.core_done) obuf <= bus.core_ciphertext;
    end
  end
endmodule
